writeback_arbiter: RTL

- Owns the single write port of the integer register file: write enable, write address and write data.
- Merges two result producers:
  - ALU results: single-cycle, no backpressure, fixed priority.
  - LSU load returns: valid/ready handshake, buffered in a small in-order FIFO.
- Enforces x0 suppression and WAW ordering between buffered loads and newer ALU writes.
- Reports pending writes so the decode stage can stall on read-after-write hazards.

---
 rtl/writeback_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - integer register file write-port arbiter (ALU + buffered loads)
//
// Purpose:
//   Owns the single write port of the integer register file. ALU results
//   take priority and are written one cycle after they arrive. Load returns
//   are handshaken into a small in-order FIFO and drained whenever the ALU
//   is idle. A newer ALU write to a register invalidates any older buffered
//   load to the same register, so write-after-write order is preserved.
//   Pending writes are exposed through a combinational hazard query.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             drop every buffered load return (ALU path unaffected)
//   alu_valid/rd/data ALU result, no backpressure
//   lsu_valid/ready   load-return handshake
//   lsu_rd/lsu_data   load destination and data
//   wb_we/addr/data   registered register file write port
//   qry_rs1/rs2       decode source registers
//   qry_hit1/hit2     a write to the queried register is still pending
//   pending_cnt       allocated FIFO entries, killed ones included

module writeback_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [ADDR_W-1:0]        lsu_rd,
   input  logic [DATA_W-1:0]        lsu_data,
   output logic                     wb_we,
   output logic [ADDR_W-1:0]        wb_addr,
   output logic [DATA_W-1:0]        wb_data,
   input  logic [ADDR_W-1:0]        qry_rs1,
   input  logic [ADDR_W-1:0]        qry_rs2,
   output logic                     qry_hit1,
   output logic                     qry_hit2,
   output logic [$clog2(DEPTH):0]   pending_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // FIFO storage
   logic [ADDR_W-1:0] ent_rd_q   [DEPTH];
   logic [ADDR_W-1:0] ent_rd_d   [DEPTH];
   logic [DATA_W-1:0] ent_data_q [DEPTH];
   logic [DATA_W-1:0] ent_data_d [DEPTH];
   logic [DEPTH-1:0]  ent_vld_q;
   logic [DEPTH-1:0]  ent_vld_d;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Output register
   logic              wb_we_q, wb_we_d;
   logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;

   logic alu_wr;
   logic fifo_room;
   logic lsu_fire;
   logic push;
   logic pop;
   logic head_vld;

   assign alu_wr    = alu_valid && (alu_rd != '0);
   // Readiness comes from the registered count only; a pop in the same
   // cycle does not grant extra room, which keeps lsu_ready off the
   // arbitration path.
   assign fifo_room = (cnt_q < CNT_W'(DEPTH));
   assign lsu_ready = fifo_room && !rst;
   assign lsu_fire  = lsu_valid && lsu_ready;

   // x0 loads, loads older than a same-edge ALU write to the same register,
   // and loads arriving with flush are all handshaken but never stored.
   assign push = lsu_fire && (lsu_rd != '0) && !flush
                 && !(alu_wr && (lsu_rd == alu_rd));
   assign pop  = !alu_wr && (cnt_q != '0) && !flush;

   assign head_vld = ent_vld_q[rd_ptr_q];

   always_comb begin
      ent_rd_d   = ent_rd_q;
      ent_data_d = ent_data_q;
      ent_vld_d  = ent_vld_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      wb_we_d    = 1'b0;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;

      // WAW kill: the ALU write supersedes every buffered load to its rd.
      if (alu_wr) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent_rd_q[i] == alu_rd) begin
               ent_vld_d[i] = 1'b0;
            end
         end
      end

      // Popped slots are invalidated so the hazard scan can look at all
      // entries without consulting the pointers.
      if (pop) begin
         ent_vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d            = rd_ptr_q + PTR_W'(1);
      end

      // The push slot is free (valid=0) whenever push is possible, so it
      // never collides with the head being popped.
      if (push) begin
         ent_rd_d[wr_ptr_q]   = lsu_rd;
         ent_data_d[wr_ptr_q] = lsu_data;
         ent_vld_d[wr_ptr_q]  = 1'b1;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end

      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

      if (flush) begin
         ent_vld_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         cnt_d     = '0;
      end

      // Write port selection: ALU first, then the FIFO head. A killed head
      // frees its slot without a write and leaves addr/data untouched.
      if (alu_wr) begin
         wb_we_d   = 1'b1;
         wb_addr_d = alu_rd;
         wb_data_d = alu_data;
      end else if (pop && head_vld) begin
         wb_we_d   = 1'b1;
         wb_addr_d = ent_rd_q[rd_ptr_q];
         wb_data_d = ent_data_q[rd_ptr_q];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_rd_q[i]   <= '0;
            ent_data_q[i] <= '0;
         end
         ent_vld_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_data_q <= '0;
      end else begin
         ent_rd_q   <= ent_rd_d;
         ent_data_q <= ent_data_d;
         ent_vld_q  <= ent_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         wb_we_q    <= wb_we_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
      end
   end

   assign wb_we       = wb_we_q;
   assign wb_addr     = wb_addr_q;
   assign wb_data     = wb_data_q;
   assign pending_cnt = cnt_q;

   // Hazard query: any live buffered load, or the write sitting in the
   // output register that the register file has not yet absorbed.
   always_comb begin
      qry_hit1 = 1'b0;
      qry_hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld_q[i] && (ent_rd_q[i] == qry_rs1)) qry_hit1 = 1'b1;
         if (ent_vld_q[i] && (ent_rd_q[i] == qry_rs2)) qry_hit2 = 1'b1;
      end
      if (wb_we_q && (wb_addr_q == qry_rs1)) qry_hit1 = 1'b1;
      if (wb_we_q && (wb_addr_q == qry_rs2)) qry_hit2 = 1'b1;
      if (qry_rs1 == '0) qry_hit1 = 1'b0;
      if (qry_rs2 == '0) qry_hit2 = 1'b0;
   end

endmodule
